// File: rtl/ace_snoop_ctrl_pkg.sv
// Shared types for the ACE snoop controller: snoop opcodes, CR response
// layout, flag write bundle and FSM states.
package ace_snoop_ctrl_pkg;

    typedef enum logic [3:0] {
        READ_ONCE             = 4'b0000,
        READ_SHARED           = 4'b0001,
        READ_CLEAN            = 4'b0010,
        READ_NOT_SHARED_DIRTY = 4'b0011,
        READ_UNIQUE           = 4'b0111,
        CLEAN_SHARED          = 4'b1000,
        CLEAN_INVALID         = 4'b1001,
        MAKE_INVALID          = 4'b1101
    } acsnoop_t;

    // Bit order matches CRRESP[4:0].
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        logic shared;
    } flag_wr_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        EVAL,
        UPDATE,
        SEND_CR,
        SEND_CD
    } state_t;

    // Snoop types this controller can service against the cache.
    function automatic logic snoop_supported(input logic [3:0] snoop);
        case (snoop)
            READ_ONCE, READ_SHARED, READ_UNIQUE,
            CLEAN_SHARED, CLEAN_INVALID, MAKE_INVALID: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic int snoop_beats(input int line_width, input int data_width);
        return line_width / data_width;
    endfunction

endpackage

// File: rtl/ace_snoop_ctrl_cd_serializer.sv
// Holds the snooped line and streams it over CD, LSB beat first.
module ace_snoop_ctrl_cd_serializer
    import ace_snoop_ctrl_pkg::*;
#(
    parameter int LineWidth      = 128,
    parameter int SnoopDataWidth = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      load_i,
    input  logic [LineWidth-1:0]      line_i,
    input  logic                      active_i,
    input  logic                      cd_ready_i,
    output logic                      cd_valid_o,
    output logic [SnoopDataWidth-1:0] cd_data_o,
    output logic                      cd_last_o,
    output logic                      done_o
);

    localparam int Beats = snoop_beats(LineWidth, SnoopDataWidth);
    localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    logic [LineWidth-1:0] line_reg;
    logic [CntW-1:0]      cnt_reg;
    logic                 last_beat;

    assign last_beat = (cnt_reg == CntW'(Beats - 1));

    // Capture the line once per snoop; step the beat counter on each accepted beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            line_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (load_i) begin
                line_reg <= line_i;
            end
            if (active_i && cd_ready_i) begin
                cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    assign cd_valid_o = active_i;
    assign cd_data_o  = active_i ? line_reg[cnt_reg*SnoopDataWidth +: SnoopDataWidth] : '0;
    assign cd_last_o  = active_i && last_beat;
    assign done_o     = active_i && cd_ready_i && last_beat;

endmodule

// File: rtl/ace_snoop_ctrl.sv
// ACE snoop controller: one snoop at a time, SRAM lookup, MOESI-lite flag
// update, CR response and CD line transfer.
module ace_snoop_ctrl
    import ace_snoop_ctrl_pkg::*;
#(
    parameter int SetAssoc       = 8,
    parameter int IndexWidth     = 12,
    parameter int TagWidth       = 44,
    parameter int LineWidth      = 128,
    parameter int SnoopDataWidth = 64,
    parameter int AddrWidth      = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          bypass_i,
    output logic                          busy_o,
    input  logic                          ac_valid_i,
    output logic                          ac_ready_o,
    input  logic [AddrWidth-1:0]          ac_addr_i,
    input  logic [3:0]                    ac_snoop_i,
    output logic                          cr_valid_o,
    input  logic                          cr_ready_i,
    output logic [4:0]                    cr_resp_o,
    output logic                          cd_valid_o,
    input  logic                          cd_ready_i,
    output logic [SnoopDataWidth-1:0]     cd_data_o,
    output logic                          cd_last_o,
    output logic [SetAssoc-1:0]           req_o,
    output logic [IndexWidth-1:0]         addr_o,
    output logic [TagWidth-1:0]           tag_o,
    input  logic                          gnt_i,
    output logic                          we_o,
    output logic [SetAssoc-1:0]           vldrty_be_o,
    output logic                          valid_o,
    output logic                          dirty_o,
    output logic                          shared_o,
    input  logic [SetAssoc*LineWidth-1:0] data_i,
    input  logic [SetAssoc-1:0]           hit_way_i,
    input  logic [SetAssoc-1:0]           dirty_way_i,
    input  logic [SetAssoc-1:0]           shared_way_i,
    input  logic                          updating_cache_i,
    input  logic                          flushing_i,
    input  logic                          amo_valid_i,
    input  logic [AddrWidth-1:0]          amo_addr_i,
    output logic                          invalidate_o,
    output logic [AddrWidth-1:0]          invalidate_addr_o
);

    localparam int OffW = $clog2(LineWidth / 8);

    state_t               state_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [3:0]           snoop_reg;
    logic [SetAssoc-1:0]  hit_reg;
    crresp_t              resp_reg;
    flag_wr_t             flags_reg;
    logic                 inval_reg;
    logic                 invalidate_reg;

    logic                 same_line, accept, cd_done;
    logic                 hit_any, hit_dirty, hit_shared;
    crresp_t              eval_resp;
    flag_wr_t             eval_flags;
    logic                 eval_update, eval_inval;
    logic [LineWidth-1:0] hit_line;
    logic [LineWidth-1:0] masked [SetAssoc];
    logic                 unused_amo_offset;

    // Only the line part of the AMO address matters for the collision check.
    assign unused_amo_offset = ^amo_addr_i[OffW-1:0];
    assign same_line = (ac_addr_i[AddrWidth-1:OffW] == amo_addr_i[AddrWidth-1:OffW]);
    assign accept    = (state_reg == IDLE) && ac_valid_i && !flushing_i && !(amo_valid_i && same_line);

    // Hit ways are one-hot, so OR-ing masked lines selects the hit line.
    for (genvar gi = 0; gi < SetAssoc; gi++) begin : g_way_mask
        assign masked[gi] = hit_way_i[gi] ? data_i[gi*LineWidth +: LineWidth] : '0;
    end

    // Collapse the per-way lines into the single hit line.
    always_comb begin
        hit_line = '0;
        for (int w = 0; w < SetAssoc; w++) begin
            hit_line = hit_line | masked[w];
        end
    end

    assign hit_any    = |hit_way_i;
    assign hit_dirty  = |(hit_way_i & dirty_way_i);
    assign hit_shared = |(hit_way_i & shared_way_i);

    // Response and flag update for the looked-up line, by snoop type.
    always_comb begin
        eval_resp   = '0;
        eval_flags  = '0;
        eval_update = 1'b0;
        eval_inval  = 1'b0;
        if (hit_any) begin
            eval_resp.was_unique = !hit_shared;
            case (snoop_reg)
                READ_ONCE: begin
                    eval_resp.data_transfer = 1'b1;
                    eval_resp.is_shared     = hit_shared;
                end
                READ_SHARED: begin
                    eval_resp.data_transfer = 1'b1;
                    eval_resp.is_shared     = 1'b1;
                    eval_update             = 1'b1;
                    eval_flags              = '{valid: 1'b1, dirty: hit_dirty, shared: 1'b1};
                end
                READ_UNIQUE: begin
                    eval_resp.data_transfer = 1'b1;
                    eval_resp.pass_dirty    = hit_dirty;
                    eval_update             = 1'b1;
                    eval_inval              = 1'b1;
                end
                CLEAN_INVALID: begin
                    eval_resp.data_transfer = hit_dirty;
                    eval_resp.pass_dirty    = hit_dirty;
                    eval_update             = 1'b1;
                    eval_inval              = 1'b1;
                end
                CLEAN_SHARED: begin
                    eval_resp.data_transfer = hit_dirty;
                    eval_resp.pass_dirty    = hit_dirty;
                    eval_resp.is_shared     = 1'b1;
                    eval_update             = 1'b1;
                    eval_flags              = '{valid: 1'b1, dirty: 1'b0, shared: 1'b1};
                end
                MAKE_INVALID: begin
                    eval_update = 1'b1;
                    eval_inval  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Snoop transaction FSM with latched request, response and update flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            snoop_reg      <= '0;
            hit_reg        <= '0;
            resp_reg       <= '0;
            flags_reg      <= '0;
            inval_reg      <= 1'b0;
            invalidate_reg <= 1'b0;
        end else begin
            invalidate_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= ac_addr_i;
                        snoop_reg <= ac_snoop_i;
                        hit_reg   <= '0;
                        flags_reg <= '0;
                        inval_reg <= 1'b0;
                        if (bypass_i) begin
                            resp_reg  <= '0;
                            state_reg <= SEND_CR;
                        end else if (!snoop_supported(ac_snoop_i)) begin
                            resp_reg  <= crresp_t'(5'b00010);
                            state_reg <= SEND_CR;
                        end else begin
                            resp_reg  <= '0;
                            state_reg <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (gnt_i && !updating_cache_i) begin
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    hit_reg   <= hit_way_i;
                    resp_reg  <= eval_resp;
                    flags_reg <= eval_flags;
                    inval_reg <= eval_inval;
                    state_reg <= eval_update ? UPDATE : SEND_CR;
                end
                UPDATE: begin
                    if (gnt_i && !updating_cache_i) begin
                        invalidate_reg <= inval_reg;
                        state_reg      <= SEND_CR;
                    end
                end
                SEND_CR: begin
                    if (cr_ready_i) begin
                        state_reg <= resp_reg.data_transfer ? SEND_CD : IDLE;
                    end
                end
                SEND_CD: begin
                    if (cd_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // SRAM request: all ways for lookup, hit way only for the flag write.
    always_comb begin
        req_o = '0;
        case (state_reg)
            IDLE:          if (accept && !bypass_i && snoop_supported(ac_snoop_i) && !updating_cache_i) req_o = '1;
            WAIT_GNT, EVAL: if (!updating_cache_i) req_o = '1;
            UPDATE:        if (!updating_cache_i) req_o = hit_reg;
            default:       req_o = '0;
        endcase
    end

    assign busy_o            = (state_reg != IDLE);
    assign ac_ready_o        = accept;
    assign addr_o            = (state_reg == IDLE) ? (accept ? ac_addr_i[IndexWidth-1:0] : '0)
                                                   : addr_reg[IndexWidth-1:0];
    assign tag_o             = (state_reg != IDLE) ? addr_reg[IndexWidth +: TagWidth] : '0;
    assign we_o              = (state_reg == UPDATE);
    assign vldrty_be_o       = (state_reg == UPDATE) ? hit_reg : '0;
    assign valid_o           = (state_reg == UPDATE) && flags_reg.valid;
    assign dirty_o           = (state_reg == UPDATE) && flags_reg.dirty;
    assign shared_o          = (state_reg == UPDATE) && flags_reg.shared;
    assign cr_valid_o        = (state_reg == SEND_CR);
    assign cr_resp_o         = (state_reg == SEND_CR) ? resp_reg : '0;
    assign invalidate_o      = invalidate_reg;
    assign invalidate_addr_o = invalidate_reg ? addr_reg : '0;

    ace_snoop_ctrl_cd_serializer #(
        .LineWidth      (LineWidth),
        .SnoopDataWidth (SnoopDataWidth)
    ) u_cd_serializer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_reg == EVAL),
        .line_i     (hit_line),
        .active_i   (state_reg == SEND_CD),
        .cd_ready_i (cd_ready_i),
        .cd_valid_o (cd_valid_o),
        .cd_data_o  (cd_data_o),
        .cd_last_o  (cd_last_o),
        .done_o     (cd_done)
    );

endmodule
